// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
// Optional write-through bypass is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 4;

  localparam logic WSRC_ALU = 1'b0;
  localparam logic WSRC_MDR = 1'b1;

  // Upper bounds for the generic field extractor below.
  localparam int BUS_MAX   = 1024;
  localparam int FIELD_MAX = 64;

  // Field k of width w from a flattened bus (caller widens the bus and narrows the result).
  function automatic logic [FIELD_MAX-1:0] field_get(input logic [BUS_MAX-1:0] bus,
                                                     input int unsigned k,
                                                     input int unsigned w);
    logic [BUS_MAX-1:0] shifted;
    shifted = bus >> (k * w);
    return shifted[FIELD_MAX-1:0] & ((FIELD_MAX'(1) << w) - FIELD_MAX'(1));
  endfunction

endpackage

// File: rtl/regfile_sb_score.sv
// Pending-write scoreboard: pending vector, reservation accept, pending count, read-port ready.
// REGFILE_BYPASS_EN makes a same-cycle write count as ready on the matching read port.
module regfile_sb_score
  import regfile_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int N_RD    = 4,
  parameter int ZERO_R0 = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_RD*ADDR_W-1:0] rd_addr,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic                   rsv_en,
  input  logic [ADDR_W-1:0]      rsv_addr,
  output logic                   rsv_ack,
  output logic [N_RD-1:0]        rd_rdy,
  output logic [ADDR_W:0]        pend_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] pend_reg, pend_next;
  logic [ADDR_W:0]  cnt_reg, cnt_next;
  logic             rsv_r0;
  logic             clr_hit;

  assign rsv_r0  = (ZERO_R0 != 0) && (rsv_addr == '0);
  assign rsv_ack = rsv_en && !pend_reg[rsv_addr] && !rsv_r0;
  assign clr_hit = wr_en && pend_reg[wr_addr];

  // Reserve is applied after the write-clear so a new producer wins on the same address.
  always_comb begin
    pend_next = pend_reg;
    if (wr_en)   pend_next[wr_addr]  = 1'b0;
    if (rsv_ack) pend_next[rsv_addr] = 1'b1;
    cnt_next = cnt_reg;
    if (rsv_ack && !clr_hit)      cnt_next = cnt_reg + (ADDR_W+1)'(1);
    else if (!rsv_ack && clr_hit) cnt_next = cnt_reg - (ADDR_W+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_reg <= '0;
      cnt_reg  <= '0;
    end else begin
      pend_reg <= pend_next;
      cnt_reg  <= cnt_next;
    end
  end

  assign pend_cnt = cnt_reg;

  for (genvar gi = 0; gi < N_RD; gi++) begin : g_rdy
    logic [ADDR_W-1:0] rd_a;
    logic              rdy_k;
    assign rd_a = ADDR_W'(field_get(BUS_MAX'(rd_addr), gi, ADDR_W));
    always_comb begin
      rdy_k = !pend_reg[rd_a];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && rd_a == wr_addr) rdy_k = !(rsv_ack && rsv_addr == rd_a);
`endif
      if (ZERO_R0 != 0 && rd_a == '0) rdy_k = 1'b1;
    end
    assign rd_rdy[gi] = rdy_k;
  end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised multi-port register file with MDR/ALU write select and a pending-write scoreboard.
// Define REGFILE_BYPASS_EN for write-through bypass on the read ports.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int N_RD    = 4,
  parameter int ZERO_R0 = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_RD*ADDR_W-1:0] rd_addr,
  output logic [N_RD*DATA_W-1:0] rd_data,
  output logic [N_RD-1:0]        rd_rdy,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic                   wr_mem_sel,
  input  logic [DATA_W-1:0]      wr_mdr_data,
  input  logic [DATA_W-1:0]      wr_alu_data,
  input  logic                   rsv_en,
  input  logic [ADDR_W-1:0]      rsv_addr,
  output logic                   rsv_ack,
  output logic [ADDR_W:0]        pend_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [DATA_W-1:0] wd;
  logic              wr_eff;

  assign wd     = (wr_mem_sel == WSRC_MDR) ? wr_mdr_data : wr_alu_data;
  assign wr_eff = wr_en && !((ZERO_R0 != 0) && (wr_addr == '0));

  // Flop array rather than block RAM: reads are asynchronous and reset clears every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else if (wr_eff) begin
      mem_reg[wr_addr] <= wd;
    end
  end

  for (genvar gi = 0; gi < N_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_d;
    assign rd_a = ADDR_W'(field_get(BUS_MAX'(rd_addr), gi, ADDR_W));
    always_comb begin
      rd_d = mem_reg[rd_a];
`ifdef REGFILE_BYPASS_EN
      if (wr_eff && rd_a == wr_addr) rd_d = wd;
`endif
      if (ZERO_R0 != 0 && rd_a == '0) rd_d = '0;
    end
    assign rd_data[gi*DATA_W +: DATA_W] = rd_d;
  end

  regfile_sb_score #(
    .ADDR_W  (ADDR_W),
    .N_RD    (N_RD),
    .ZERO_R0 (ZERO_R0)
  ) u_score (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rsv_ack  (rsv_ack),
    .rd_rdy   (rd_rdy),
    .pend_cnt (pend_cnt)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: two instances (ZERO_R0=0 and 1) share stimulus and are checked
// against an array-based reference model; honours REGFILE_BYPASS_EN like the design.
module tb_regfile_sb;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NR = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NR*AW-1:0]  rd_addr;
  logic              wr_en, wr_mem_sel, rsv_en;
  logic [AW-1:0]     wr_addr, rsv_addr;
  logic [DW-1:0]     wr_mdr_data, wr_alu_data;

  logic [NR*DW-1:0]  rd_data0, rd_data1;
  logic [NR-1:0]     rd_rdy0, rd_rdy1;
  logic              rsv_ack0, rsv_ack1;
  logic [AW:0]       pend_cnt0, pend_cnt1;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR), .ZERO_R0(0)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_rdy(rd_rdy0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_mem_sel(wr_mem_sel),
    .wr_mdr_data(wr_mdr_data), .wr_alu_data(wr_alu_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ack(rsv_ack0), .pend_cnt(pend_cnt0)
  );

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR), .ZERO_R0(1)) dut_z (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_rdy(rd_rdy1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_mem_sel(wr_mem_sel),
    .wr_mdr_data(wr_mdr_data), .wr_alu_data(wr_alu_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ack(rsv_ack1), .pend_cnt(pend_cnt1)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: index 0 models ZERO_R0=0, index 1 models ZERO_R0=1.
  logic [DW-1:0] m_reg  [2][DEPTH];
  bit            m_pend [2][DEPTH];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++)
      for (int r = 0; r < DEPTH; r++) begin
        m_reg[i][r]  = '0;
        m_pend[i][r] = 1'b0;
      end
  endtask

  // Compare one instance's combinational outputs against the model, then advance the model.
  task automatic eval(input int i, input logic [NR*DW-1:0] o_data, input logic [NR-1:0] o_rdy,
                      input logic o_ack, input logic [AW:0] o_cnt);
    bit            z, wr_ok, ack, r;
    logic [DW-1:0] wd, d;
    logic [AW-1:0] a;
    logic [NR*DW-1:0] exp_data;
    logic [NR-1:0]    exp_rdy;
    int            cnt;
    z     = (i == 1);
    wd    = wr_mem_sel ? wr_mdr_data : wr_alu_data;
    wr_ok = wr_en && !(z && wr_addr == 0);
    ack   = rsv_en && !m_pend[i][rsv_addr] && !(z && rsv_addr == 0);
    for (int k = 0; k < NR; k++) begin
      a = rd_addr[k*AW +: AW];
      if (z && a == 0) begin
        d = '0;
        r = 1'b1;
      end else begin
        d = m_reg[i][a];
        r = !m_pend[i][a];
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && a == wr_addr) begin
          d = wd;
          r = !(ack && rsv_addr == a);
        end
`endif
      end
      exp_data[k*DW +: DW] = d;
      exp_rdy[k] = r;
    end
    cnt = 0;
    for (int q = 0; q < DEPTH; q++) cnt += int'(m_pend[i][q]);
    check($sformatf("u%0d_rd_data", i), 64'(o_data), 64'(exp_data));
    check($sformatf("u%0d_rd_rdy", i), 64'(o_rdy), 64'(exp_rdy));
    check($sformatf("u%0d_rsv_ack", i), 64'(o_ack), 64'(ack));
    check($sformatf("u%0d_pend_cnt", i), 64'(o_cnt), 64'(cnt));
    if (wr_ok) begin
      m_reg[i][wr_addr]  = wd;
      m_pend[i][wr_addr] = 1'b0;
    end
    if (ack) m_pend[i][rsv_addr] = 1'b1;
  endtask

  task automatic cycle(input logic we, input logic [AW-1:0] wa, input logic sel,
                       input logic [DW-1:0] mdr, input logic [DW-1:0] alu,
                       input logic re, input logic [AW-1:0] ra, input logic [NR*AW-1:0] rda);
    wr_en = we; wr_addr = wa; wr_mem_sel = sel; wr_mdr_data = mdr; wr_alu_data = alu;
    rsv_en = re; rsv_addr = ra; rd_addr = rda;
    @(negedge clk);
    eval(0, rd_data0, rd_rdy0, rsv_ack0, pend_cnt0);
    eval(1, rd_data1, rd_rdy1, rsv_ack1, pend_cnt1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    wr_en = 1'b1; wr_addr = 4'd5; wr_mem_sel = 1'b0; wr_alu_data = 16'hFFFF; wr_mdr_data = 16'hFFFF;
    rsv_en = 1'b1; rsv_addr = 4'd6; rd_addr = '0;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  function automatic logic [NR*AW-1:0] addrs(input logic [AW-1:0] a3, input logic [AW-1:0] a2,
                                             input logic [AW-1:0] a1, input logic [AW-1:0] a0);
    return {a3, a2, a1, a0};
  endfunction

  initial begin
    logic [AW-1:0] wa, ra;
    logic [NR*AW-1:0] rda;

    do_reset(2);
    // All sixteen registers read back as zero after reset.
    for (int j = 0; j < 4; j++)
      cycle(0, 0, 0, 0, 0, 0, 0,
            addrs(AW'(4*j+3), AW'(4*j+2), AW'(4*j+1), AW'(4*j)));

    // ALU-sourced then MDR-sourced writes to r5, read on ports 0 and 3.
    cycle(1, 5, 0, 16'h7777, 16'hBEEF, 0, 0, addrs(5, 1, 2, 5));
    cycle(0, 0, 0, 0, 0, 0, 0, addrs(5, 1, 2, 5));
    cycle(1, 5, 1, 16'h1234, 16'h8888, 0, 0, addrs(5, 1, 2, 5));
    cycle(0, 0, 0, 0, 0, 0, 0, addrs(5, 1, 2, 5));

    // Load hazard on r7: reserve, refused re-reserve, writeback clears.
    cycle(0, 0, 0, 0, 0, 1, 7, addrs(0, 0, 0, 7));
    cycle(0, 0, 0, 0, 0, 1, 7, addrs(0, 0, 0, 7));
    cycle(1, 7, 0, 0, 16'h00A5, 0, 0, addrs(0, 0, 0, 7));
    cycle(0, 0, 0, 0, 0, 0, 0, addrs(0, 0, 0, 7));

    // Same-cycle write and reserve to a non-pending r3.
    cycle(1, 3, 0, 0, 16'h0F0F, 1, 3, addrs(0, 0, 3, 3));
    cycle(0, 0, 0, 0, 0, 0, 0, addrs(0, 0, 3, 3));

    // Read r9 while it is being written.
    cycle(1, 9, 1, 16'hCAFE, 0, 0, 0, addrs(9, 9, 9, 9));
    cycle(0, 0, 0, 0, 0, 0, 0, addrs(9, 9, 9, 9));

    // Write and reserve r0, then reserve everything else.
    cycle(1, 0, 0, 0, 16'hFFFF, 1, 0, addrs(0, 0, 0, 0));
    cycle(0, 0, 0, 0, 0, 0, 0, addrs(0, 0, 0, 0));
    for (int r = 1; r < DEPTH; r++)
      cycle(0, 0, 0, 0, 0, 1, AW'(r), addrs(0, 3, 7, AW'(r)));
    check("z_pend_cnt_full", 64'(pend_cnt1), 64'd15);
    check("u0_pend_cnt_full", 64'(pend_cnt0), 64'd16);
    cycle(0, 0, 0, 0, 0, 1, 4, addrs(15, 8, 1, 0));

    // Randomized traffic with biased address collisions and a mid-run reset.
    for (int n = 0; n < 1500; n++) begin
      if (n == 700) do_reset(1);
      wa  = AW'($urandom_range(0, DEPTH-1));
      ra  = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, DEPTH-1));
      rda = NR*AW'($urandom);
      if ($urandom_range(0, 2) == 0) rda[AW-1:0] = wa;
      cycle(1'($urandom_range(0, 1)), wa, 1'($urandom_range(0, 1)),
            DW'($urandom), DW'($urandom), 1'($urandom_range(0, 1)), ra, rda);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
